// File: rtl/sig_deintlv_pkg.sv
// Shared geometry and helpers for the SIGNAL-field de-interleaver.
// The symbol is a 16-column by 3-row BPSK block of 48 coded bits.
package sig_deintlv_pkg;

  localparam int DEINTLV_NCOL = 16;
  localparam int DEINTLV_NROW = 3;
  localparam int N_CBPS_SIG   = DEINTLV_NCOL * DEINTLV_NROW;

  localparam logic [5:0] LAST_IDX = 6'(N_CBPS_SIG - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  // Step down a column (+NROW), wrapping to the top of the next row.
  function automatic logic [5:0] next_raddr(input logic [5:0] a);
    logic [6:0] s;
    s = {1'b0, a} + 7'(DEINTLV_NROW);
    if (s >= 7'(N_CBPS_SIG)) begin
      s = s - 7'(N_CBPS_SIG - 1);
    end
    return s[5:0];
  endfunction

endpackage

// File: rtl/sig_deintlv_addr_gen.sv
// Read-side sequencer: walks k=0..47 and produces the de-interleave address
// incrementally, restarting whenever a new symbol becomes available.
module sig_deintlv_addr_gen
  import sig_deintlv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] raddr,
  output logic       active,
  output logic       last
);

  rd_state_e  state_q, state_d;
  logic [5:0] k_q, k_d;
  logic [5:0] raddr_q, raddr_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    raddr_d = raddr_q;
    if (start) begin
      // A new symbol always wins, even mid-read.
      state_d = ST_READ;
      k_d     = '0;
      raddr_d = '0;
    end else if (state_q == ST_READ) begin
      if (k_q == LAST_IDX) begin
        state_d = ST_IDLE;
      end else begin
        k_d     = k_q + 6'd1;
        raddr_d = next_raddr(raddr_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      raddr_q <= raddr_d;
    end
  end

  assign raddr  = raddr_q;
  assign active = (state_q == ST_READ);
  assign last   = (state_q == ST_READ) && (k_q == LAST_IDX);

endmodule

// File: rtl/sig_deintlv.sv
// SIGNAL-field de-interleaver: ping-pong 48-bit banks written in interleaved
// order and read back in pre-interleaver order with one cycle of latency.
module sig_deintlv
  import sig_deintlv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic di,
  input  logic di_vld,
  output logic dout,
  output logic do_vld,
  output logic err
);

  logic [5:0]            wcnt_q, wcnt_d;
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [N_CBPS_SIG-1:0] bank_q [2];
  logic [N_CBPS_SIG-1:0] bank_d [2];
  logic                  dout_q, dout_d;
  logic                  do_vld_q, do_vld_d;
  logic                  err_q, err_d;

  logic       start;
  logic       active;
  logic       last;
  logic [5:0] raddr;

  assign start = di_vld && (wcnt_q == LAST_IDX);

  sig_deintlv_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .raddr  (raddr),
    .active (active),
    .last   (last)
  );

  always_comb begin
    wcnt_d   = wcnt_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    bank_d   = bank_q;
    dout_d   = dout_q;
    do_vld_d = active;
    // A completed symbol before the current read reached k=47 is an overrun.
    err_d    = start && active && !last;
    if (di_vld) begin
      bank_d[wsel_q][wcnt_q] = di;
      if (wcnt_q == LAST_IDX) begin
        wcnt_d = '0;
        wsel_d = ~wsel_q;
        rsel_d = wsel_q;
      end else begin
        wcnt_d = wcnt_q + 6'd1;
      end
    end
    if (active) begin
      dout_d = bank_q[rsel_q][raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q   <= '0;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      dout_q   <= 1'b0;
      do_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      dout_q   <= dout_d;
      do_vld_q <= do_vld_d;
      err_q    <= err_d;
    end
  end

  // Bank contents carry no state worth resetting.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign dout   = dout_q;
  assign do_vld = do_vld_q;
  assign err    = err_q;

endmodule
